// File: rtl/fetch_pkg.sv
// Shared definitions for the handshaked fetch stage.
//   fetchState_t      : fetch FSM states (REQ, WAIT, HOLD, DROP)
//   NOP_INSTR_DEFAULT : instruction placed in IF/ID on flush or bubble
//   alignWord()       : clears the two low address bits of a target PC
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,  // request outstanding on the bus, waiting for a grant
    WAIT = 2'd1,  // granted, waiting for the response
    HOLD = 2'd2,  // response parked in the hold buffer while decode stalls
    DROP = 2'd3   // a squashed response is still in flight and must be discarded
  } fetchState_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  function automatic logic [31:0] alignWord(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register with flush and stall control.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : squash contents to a NOP bubble (highest priority)
//   stall             : keep current contents
//   load              : capture instrIn/pcIn/pcPlus4In/validIn
//   instr/pc/pcPlus4/valid : registered IF/ID contents
// With neither flush, stall nor load the register takes a NOP bubble, so a
// given instruction is presented to decode only until decode accepts it.
module fetch_ifid_reg #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [31:0]     instrIn,
  input  logic [XLEN-1:0] pcIn,
  input  logic [XLEN-1:0] pcPlus4In,
  input  logic            validIn,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  output logic            valid
);

  // IF/ID register update: flush > stall > load > bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr   <= NOP_INSTR;
      pc      <= {XLEN{1'b0}};
      pcPlus4 <= {XLEN{1'b0}};
      valid   <= 1'b0;
    end else if (flush) begin
      instr   <= NOP_INSTR;
      pc      <= {XLEN{1'b0}};
      pcPlus4 <= {XLEN{1'b0}};
      valid   <= 1'b0;
    end else if (stall) begin
      instr   <= instr;
      pc      <= pc;
      pcPlus4 <= pcPlus4;
      valid   <= valid;
    end else if (load) begin
      instr   <= instrIn;
      pc      <= pcIn;
      pcPlus4 <= pcPlus4In;
      valid   <= validIn;
    end else begin
      instr   <= NOP_INSTR;
      pc      <= {XLEN{1'b0}};
      pcPlus4 <= {XLEN{1'b0}};
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_adder.sv
// PC incrementer.
//   pc      : current program counter
//   pcPlus4 : pc + 4, wrapping modulo 2^XLEN
module pc_adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4
);

  assign pcPlus4 = pc + XLEN'(32'd4);

endmodule

// File: rtl/fetch_stage_hs.sv
// Fetch stage with a single-outstanding req/gnt/rvalid instruction-memory port.
//   clk, rst_n      : clock, asynchronous active-low reset
//   redirect_i      : execute-stage taken branch/jump; redirect_pc_i is the target
//   stall_d_i       : decode cannot accept; IF/ID is frozen
//   imem_req_o      : fetch request valid (only in REQ)
//   imem_addr_o     : fetch address, always the current fetch PC
//   imem_gnt_i      : memory accepts the request this cycle
//   imem_rvalid_i   : response valid, imem_rdata_i carries the instruction
//   instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o : IF/ID contents
module fetch_stage_hs
  import fetch_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = {XLEN{1'b0}},
  parameter logic [31:0]      NOP_INSTR    = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_d_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     instr_d_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic [XLEN-1:0] pc_plus4_d_o,
  output logic            valid_d_o
);

  fetchState_t     state;
  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] pcPlus4F;
  logic [XLEN-1:0] redirectTarget;
  logic            reqR;
  logic            granted;

  // One-entry hold buffer for a response that arrived while decode stalled.
  logic [31:0]     holdInstr;
  logic [XLEN-1:0] holdPc;
  logic            holdValid;

  // IF/ID load path.
  logic            ifidLoad;
  logic            ifidFromHold;
  logic [31:0]     ifidInstrIn;
  logic [XLEN-1:0] ifidPcIn;
  logic [XLEN-1:0] ifidPcPlus4In;
  logic            ifidValidIn;

  assign redirectTarget = {redirect_pc_i[XLEN-1:2], 2'b00};
  // A grant only counts while the request is actually being driven; right
  // after reset the FSM is in REQ but req is still low for one cycle.
  assign granted        = reqR & imem_gnt_i;

  assign imem_req_o  = reqR;
  assign imem_addr_o = pcF;

  pc_adder #(.XLEN(XLEN)) u_pcInc (
    .pc      (pcF),
    .pcPlus4 (pcPlus4F)
  );

  pc_adder #(.XLEN(XLEN)) u_ifidInc (
    .pc      (ifidPcIn),
    .pcPlus4 (ifidPcPlus4In)
  );

  // Select what IF/ID captures and when; redirect suppresses any write.
  always_comb begin
    ifidLoad     = 1'b0;
    ifidFromHold = 1'b0;
    if (redirect_i) begin
      ifidLoad     = 1'b0;
      ifidFromHold = 1'b0;
    end else begin
      case (state)
        WAIT: begin
          ifidFromHold = 1'b0;
          ifidLoad     = imem_rvalid_i & ~stall_d_i;
        end
        HOLD: begin
          ifidFromHold = 1'b1;
          ifidLoad     = ~stall_d_i;
        end
        default: begin
          // REQ and DROP never write IF/ID; rvalid there is ignored.
          ifidFromHold = 1'b0;
          ifidLoad     = 1'b0;
        end
      endcase
    end
  end

  assign ifidInstrIn = ifidFromHold ? holdInstr : imem_rdata_i;
  assign ifidPcIn    = ifidFromHold ? holdPc    : pcF;
  assign ifidValidIn = ifidFromHold ? holdValid : 1'b1;

  // Fetch FSM: state, fetch PC, hold buffer and registered request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= REQ;
      pcF       <= RESET_VECTOR;
      reqR      <= 1'b0;
      holdInstr <= NOP_INSTR;
      holdPc    <= {XLEN{1'b0}};
      holdValid <= 1'b0;
    end else if (redirect_i) begin
      // A redirect always wins; a response already in flight must be drained
      // in DROP unless it is arriving in this very cycle.
      pcF       <= redirectTarget;
      holdInstr <= NOP_INSTR;
      holdPc    <= {XLEN{1'b0}};
      holdValid <= 1'b0;
      case (state)
        REQ: begin
          if (granted) begin
            state <= DROP;
            reqR  <= 1'b0;
          end else begin
            state <= REQ;
            reqR  <= 1'b1;
          end
        end
        WAIT, DROP: begin
          if (imem_rvalid_i) begin
            state <= REQ;
            reqR  <= 1'b1;
          end else begin
            state <= DROP;
            reqR  <= 1'b0;
          end
        end
        HOLD: begin
          state <= REQ;
          reqR  <= 1'b1;
        end
        default: begin
          state <= REQ;
          reqR  <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        REQ: begin
          if (granted) begin
            state <= WAIT;
            reqR  <= 1'b0;
          end else begin
            state <= REQ;
            reqR  <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid_i && stall_d_i) begin
            holdInstr <= imem_rdata_i;
            holdPc    <= pcF;
            holdValid <= 1'b1;
            state     <= HOLD;
            reqR      <= 1'b0;
          end else if (imem_rvalid_i) begin
            pcF   <= pcPlus4F;
            state <= REQ;
            reqR  <= 1'b1;
          end else begin
            state <= WAIT;
            reqR  <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall_d_i) begin
            pcF       <= pcPlus4F;
            holdInstr <= NOP_INSTR;
            holdPc    <= {XLEN{1'b0}};
            holdValid <= 1'b0;
            state     <= REQ;
            reqR      <= 1'b1;
          end else begin
            state <= HOLD;
            reqR  <= 1'b0;
          end
        end
        DROP: begin
          if (imem_rvalid_i) begin
            state <= REQ;
            reqR  <= 1'b1;
          end else begin
            state <= DROP;
            reqR  <= 1'b0;
          end
        end
        default: begin
          state <= REQ;
          reqR  <= 1'b0;
        end
      endcase
    end
  end

  fetch_ifid_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .stall     (stall_d_i),
    .load      (ifidLoad),
    .instrIn   (ifidInstrIn),
    .pcIn      (ifidPcIn),
    .pcPlus4In (ifidPcPlus4In),
    .validIn   (ifidValidIn),
    .instr     (instr_d_o),
    .pc        (pc_d_o),
    .pcPlus4   (pc_plus4_d_o),
    .valid     (valid_d_o)
  );

endmodule

// File: tb/tb_fetch_stage_hs.sv
// Self-checking bench for fetch_stage_hs. A memory model answers granted
// requests with 0xAAAA0000+addr after a random latency; a reference model
// tracks the PC of the next instruction decode should receive and checks
// every instruction decode accepts, plus address/request stability rules.
module tb_fetch_stage_hs;

  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirPc;
  logic        stall;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pc4D;
  logic        validD;

  always #5 clk = ~clk;

  fetch_stage_hs #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .NOP_INSTR    (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirPc),
    .stall_d_i     (stall),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_d_o     (instrD),
    .pc_d_o        (pcD),
    .pc_plus4_d_o  (pc4D),
    .valid_d_o     (validD)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] expPc;
  bit          pending;
  int          cnt;
  logic [31:0] pendAddr;
  int          cyc;
  int          consumed;
  int          firstGrant;
  int          firstValid;
  logic [31:0] grantAddrs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus + checking. rnd=0: always grant, 1-cycle memory,
  // no stall, no redirect. rnd=1: everything randomized.
  task automatic cycle(input bit rnd);
    logic        preReq;
    logic [31:0] preAddr;
    logic        granted;
    logic [31:0] tgt;
    logic [31:0] pI, pP, pP4;
    logic        pV;
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = 32'h0;
    if (pending) begin
      if (cnt <= 1) begin
        rvalid  = 1'b1;
        rdata   = 32'hAAAA_0000 + pendAddr;
        pending = 1'b0;
      end else begin
        cnt--;
      end
    end else if (rnd && $urandom_range(0, 19) == 0) begin
      rvalid = 1'b1;            // spurious response, must be ignored
      rdata  = 32'hDEAD_BEEF;
    end
    gnt      = !pending && (!rnd || $urandom_range(0, 2) != 0);
    stall    = rnd && ($urandom_range(0, 3) == 0);
    redirect = rnd && ($urandom_range(0, 15) == 0);
    tgt      = $urandom;
    tgt[31:12] = 20'h0;
    redirPc  = tgt;

    // Decode accepts the IF/ID instruction at this edge.
    if (validD && !stall) begin
      chk("pc_d", pcD, expPc);
      chk("pc_plus4_d", pc4D, expPc + 32'd4);
      chk("instr_d", instrD, 32'hAAAA_0000 + expPc);
      expPc = expPc + 32'd4;
      consumed++;
    end
    if (validD && firstValid < 0) firstValid = cyc;
    if (!validD) chk("bubble_nop", instrD, NOP);

    granted = req && gnt;
    if (granted) begin
      pending  = 1'b1;
      cnt      = rnd ? int'($urandom_range(1, 4)) : 1;
      pendAddr = addr;
      grantAddrs.push_back(addr);
      if (firstGrant < 0) firstGrant = cyc;
    end
    preReq = req; preAddr = addr;
    pI = instrD; pP = pcD; pP4 = pc4D; pV = validD;

    @(posedge clk);
    #1;
    if (redirect) begin
      expPc = tgt & 32'hFFFF_FFFC;
      chk("addr_redirect", addr, expPc);
      chk("valid_after_redirect", {31'd0, validD}, 32'd0);
    end else if (preReq && !granted) begin
      chk("req_held", {31'd0, req}, 32'd1);
      chk("addr_held", addr, preAddr);
    end else if (granted) begin
      chk("req_low_after_gnt", {31'd0, req}, 32'd0);
    end
    if (stall && !redirect) begin
      chk("stall_instr", instrD, pI);
      chk("stall_pc", pcD, pP);
      chk("stall_pc4", pc4D, pP4);
      chk("stall_valid", {31'd0, validD}, {31'd0, pV});
    end
    cyc++;
  endtask

  task automatic checkReset();
    chk("rst_instr", instrD, NOP);
    chk("rst_pc_d", pcD, 32'd0);
    chk("rst_pc4_d", pc4D, 32'd0);
    chk("rst_valid", {31'd0, validD}, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_addr", addr, RV);
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirPc = 32'h0; stall = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    pending = 1'b0; cnt = 0; pendAddr = 32'h0;
    cyc = 0; consumed = 0; firstGrant = -1; firstValid = -1;
    expPc = RV;

    // Reset state.
    repeat (3) @(negedge clk);
    checkReset();
    rst_n = 1'b1;

    // Directed: 1-cycle memory, no stalls or redirects.
    for (int i = 0; i < 30; i++) cycle(1'b0);
    chk("first_latency", 32'(firstValid - firstGrant), 32'd2);
    chk("grant_count", {31'd0, grantAddrs.size() >= 3}, 32'd1);
    if (grantAddrs.size() >= 3) begin
      chk("grant_addr0", grantAddrs[0], 32'h100);
      chk("grant_addr1", grantAddrs[1], 32'h104);
      chk("grant_addr2", grantAddrs[2], 32'h108);
    end

    // Randomized: grant delays, latencies, stalls, redirects, spurious rvalid.
    for (int i = 0; i < 3000; i++) cycle(1'b1);
    chk("progress", {31'd0, consumed >= 100}, 32'd1);

    // Asynchronous reset while a response is outstanding.
    for (int i = 0; i < 50 && !pending; i++) cycle(1'b1);
    chk("pending_before_reset", {31'd0, pending}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    #1;
    checkReset();
    @(negedge clk);
    rst_n = 1'b1;
    expPc = RV;
    for (int i = 0; i < 400; i++) cycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
